// File: rtl/fs_dither_engine.sv
// fs_dither_engine: streaming Floyd-Steinberg ditherer. Quantises a raster-order greyscale
// stream to OUT_W-bit codes and diffuses the error right and into the next row through a
// MAX_W-deep line buffer of pending errors, held in sixteenths.
// Optional feature macro: FS_SERPENTINE_EN (odd rows are processed right-to-left).
module fs_dither_engine #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned OUT_W = 1,
   parameter int unsigned MAX_W = 640,
   parameter int unsigned XW    = $clog2(MAX_W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [XW-1:0]    img_w,
   input  logic [15:0]      img_h,
   output logic             busy,
   output logic             frame_done,
   output logic             cfg_err,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [PIX_W-1:0] s_pix,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [OUT_W-1:0] m_code,
   output logic             m_eol,
   output logic             m_eof
);

   localparam int unsigned AW  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam int unsigned EW  = PIX_W + 1;   // quantisation error
   localparam int unsigned SW  = PIX_W + 5;   // line buffer entry / partial sum
   localparam int unsigned CW  = PIX_W + 6;   // corrected pixel before clamping
   localparam int unsigned REP = (PIX_W + OUT_W - 1) / OUT_W;

   typedef enum logic [1:0] {StIdle, StRun, StEol, StDone} state_e;

   state_e               state_q, state_d;
   logic [XW-1:0]        x_q, x_d, w_q, w_d;
   logic [15:0]          y_q, y_d, h_q, h_d;
   logic signed [EW-1:0] e_prev_q, e_prev_d;
   logic signed [SW-1:0] part_q, part_d;
   logic                 busy_q, busy_d;
   logic                 frame_done_q, frame_done_d;
   logic                 cfg_err_q, cfg_err_d;
   logic                 m_valid_q, m_eol_q, m_eof_q;
   logic [OUT_W-1:0]     m_code_q;

   logic signed [SW-1:0] lb [MAX_W];
   logic                 lb_we;
   logic [XW-1:0]        lb_waddr;
   logic signed [SW-1:0] lb_wdata;

   logic                 accept, cfg_ok, first_x, last_x, last_row;
   logic [XW-1:0]        x_adv, row_waddr, eol_waddr, x_row_start;

   logic signed [SW-1:0] s_rd, e_s, ep_s, e3, e5;
   logic signed [CW-1:0] e_prev_x, s_x, pix_x, acc_x, c;
   logic [PIX_W-1:0]     cc, recon;
   logic [REP*OUT_W-1:0] rep;
   logic [OUT_W-1:0]     code;
   logic signed [EW-1:0] e;

   assign s_ready    = (state_q == StRun) && (!m_valid_q || m_ready);
   assign accept     = s_valid && s_ready;
   assign cfg_ok     = (img_w != '0) && (img_w <= XW'(MAX_W)) && (img_h != '0);
   assign last_row   = (y_q == h_q - 16'd1);

   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign cfg_err    = cfg_err_q;
   assign m_valid    = m_valid_q;
   assign m_code     = m_code_q;
   assign m_eol      = m_eol_q;
   assign m_eof      = m_eof_q;

`ifdef FS_SERPENTINE_EN
   // Odd rows run right-to-left; the lagging next-row write sits on the x+1 side.
   logic rev;
   assign rev         = y_q[0];
   assign first_x     = rev ? (x_q == w_q - XW'(1)) : (x_q == '0);
   assign last_x      = rev ? (x_q == '0) : (x_q == w_q - XW'(1));
   assign x_adv       = rev ? (x_q - XW'(1)) : (x_q + XW'(1));
   assign row_waddr   = rev ? (x_q + XW'(1)) : (x_q - XW'(1));
   assign eol_waddr   = rev ? '0 : (w_q - XW'(1));
   assign x_row_start = rev ? '0 : (w_q - XW'(1));  // next row has the opposite direction
`else
   assign first_x     = (x_q == '0);
   assign last_x      = (x_q == w_q - XW'(1));
   assign x_adv       = x_q + XW'(1);
   assign row_waddr   = x_q - XW'(1);
   assign eol_waddr   = w_q - XW'(1);
   assign x_row_start = '0;
`endif

   // Error-corrected pixel, clamp, quantise and the diffusion terms.
   always_comb begin
      s_rd     = (y_q == '0) ? '0 : lb[x_q[AW-1:0]];  // row 0 ignores stale buffer contents
      e_prev_x = {{(CW-EW){e_prev_q[EW-1]}}, e_prev_q};
      s_x      = {{(CW-SW){s_rd[SW-1]}}, s_rd};
      pix_x    = {{(CW-PIX_W){1'b0}}, s_pix};
      acc_x    = (e_prev_x <<< 3) - e_prev_x + s_x;
      c        = pix_x + (acc_x >>> 4);               // arithmetic shift floors
      if (c[CW-1]) begin
         cc = '0;
      end else if (|c[CW-2:PIX_W]) begin
         cc = '1;
      end else begin
         cc = c[PIX_W-1:0];
      end
      code  = cc[PIX_W-1 -: OUT_W];
      rep   = {REP{code}};
      recon = rep[REP*OUT_W-1 -: PIX_W];              // code bit-replicated, MSB first
      e     = $signed({1'b0, cc}) - $signed({1'b0, recon});
      e_s   = {{(SW-EW){e[EW-1]}}, e};
      ep_s  = {{(SW-EW){e_prev_q[EW-1]}}, e_prev_q};
      e3    = (e_s <<< 1) + e_s;
      e5    = (e_s <<< 2) + e_s;
   end

   // Control FSM next state, error pipeline and line buffer write port.
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      w_d          = w_q;
      h_d          = h_q;
      e_prev_d     = e_prev_q;
      part_d       = part_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      cfg_err_d    = 1'b0;
      lb_we        = 1'b0;
      lb_waddr     = '0;
      lb_wdata     = '0;
      case (state_q)
         StIdle: begin
            if (start) begin
               if (cfg_ok) begin
                  state_d  = StRun;
                  x_d      = '0;
                  y_d      = '0;
                  w_d      = img_w;
                  h_d      = img_h;
                  e_prev_d = '0;
                  part_d   = '0;
                  busy_d   = 1'b1;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         StRun: begin
            if (accept) begin
               // The first pixel of a row has no left-behind neighbour for its 3/16 share.
               if (!first_x) begin
                  lb_we    = 1'b1;
                  lb_waddr = row_waddr;
                  lb_wdata = part_q + e3;
               end
               part_d   = ep_s + e5;
               e_prev_d = e;
               if (last_x) begin
                  state_d = StEol;
               end else begin
                  x_d = x_adv;
               end
            end
         end
         StEol: begin
            lb_we    = 1'b1;
            lb_waddr = eol_waddr;
            lb_wdata = part_q;
            e_prev_d = '0;
            part_d   = '0;
            if (last_row) begin
               state_d = StDone;
            end else begin
               state_d = StRun;
               y_d     = y_q + 16'd1;
               x_d     = x_row_start;
            end
         end
         StDone: begin
            if (!m_valid_q || m_ready) begin
               state_d      = StIdle;
               frame_done_d = 1'b1;
               busy_d       = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control and error state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         x_q          <= '0;
         y_q          <= '0;
         w_q          <= '0;
         h_q          <= '0;
         e_prev_q     <= '0;
         part_q       <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         w_q          <= w_d;
         h_q          <= h_d;
         e_prev_q     <= e_prev_d;
         part_q       <= part_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   // Output register: loads on accept, holds while stalled, empties on m_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q <= 1'b0;
         m_code_q  <= '0;
         m_eol_q   <= 1'b0;
         m_eof_q   <= 1'b0;
      end else if (accept) begin
         m_valid_q <= 1'b1;
         m_code_q  <= code;
         m_eol_q   <= last_x;
         m_eof_q   <= last_x && last_row;
      end else if (m_ready) begin
         m_valid_q <= 1'b0;
      end
   end

   // Next-row error line buffer; never cleared.
   always_ff @(posedge clk) begin
      if (lb_we) begin
         lb[lb_waddr[AW-1:0]] <= lb_wdata;
      end
   end

endmodule

// File: tb/tb_fs_dither_engine.sv
// Directed bench for fs_dither_engine (PIX_W=8, OUT_W=1, MAX_W=640) with hand-computed codes.
// Define FS_SERPENTINE_EN to also run the mirrored-row vector.
module tb_fs_dither_engine;

   localparam int XW = 10;

   logic          clk = 1'b0;
   logic          rst_n, start, s_valid, m_ready;
   logic [XW-1:0] img_w;
   logic [15:0]   img_h;
   logic [7:0]    s_pix;
   logic          busy, frame_done, cfg_err, s_ready, m_valid, m_eol, m_eof;
   logic [0:0]    m_code;

   int vectors = 0;
   int miscompares = 0;

   bit         codes[$];
   bit         eols[$];
   bit         eofs[$];
   logic [7:0] pix[$];
   int         cyc = 0;
   int         hs_cyc = 0;
   int         fd_cyc = 0;
   int         fd_cnt = 0;
   int         ce_cnt = 0;
   logic       busy_at_fd = 1'b0;

   fs_dither_engine dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .img_w      (img_w),
      .img_h      (img_h),
      .busy       (busy),
      .frame_done (frame_done),
      .cfg_err    (cfg_err),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_pix      (s_pix),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_code     (m_code),
      .m_eol      (m_eol),
      .m_eof      (m_eof)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (m_valid && m_ready) begin
         codes.push_back(m_code[0]);
         eols.push_back(m_eol);
         eofs.push_back(m_eof);
         hs_cyc <= cyc;
      end
      if (frame_done) begin
         fd_cnt     <= fd_cnt + 1;
         fd_cyc     <= cyc;
         busy_at_fd <= busy;
      end
      if (cfg_err) ce_cnt <= ce_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic fill(input int n, input int v);
      pix.delete();
      for (int i = 0; i < n; i++) pix.push_back(8'(v));
   endtask

   task automatic start_frame(input int w, input int h);
      @(posedge clk); #1;
      img_w = XW'(w);
      img_h = 16'(h);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Present pix[0..n-1] in order; counts cycles spent waiting on s_ready.
   task automatic feed(input int n, output int waits);
      bit acc;
      int k;
      waits = 0;
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_pix   = pix[i];
         acc     = 1'b0;
         k       = 0;
         while (!acc && k < 200) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk); #1;
            if (!acc) waits++;
            k++;
         end
         if (!acc) begin
            check("feed_accept", 64'(acc), 64'd1);
            break;
         end
      end
      s_valid = 1'b0;
   endtask

   // After the 2nd output, hold m_ready low for 3 cycles and watch the stall.
   task automatic stall_after_two();
      int n;
      int k;
      n = 0;
      k = 0;
      while (n < 2 && k < 100) begin
         @(negedge clk);
         if (m_valid && m_ready) n++;
         k++;
      end
      @(posedge clk); #1;
      m_ready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("stall_s_ready", 64'(s_ready), 64'd0);
         check("stall_m_valid", 64'(m_valid), 64'd1);
         check("stall_m_code", 64'(m_code), 64'd1);
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
   endtask

   task automatic run_frame(input string tag, input int w, input int h,
                            input logic [63:0] exp_code, input logic [63:0] exp_eol,
                            input logic [63:0] exp_eof, input int exp_waits,
                            input bit do_stall);
      int base;
      int fd0;
      int waits;
      int n;
      logic [63:0] gc, ge, gf;
      base = codes.size();
      fd0  = fd_cnt;
      n    = w * h;
      start_frame(w, h);
      check({tag, "_busy"}, 64'(busy), 64'd1);
      fork
         feed(n, waits);
         if (do_stall) stall_after_two();
      join
      repeat (8) @(posedge clk);
      #1;
      gc = '0;
      ge = '0;
      gf = '0;
      for (int i = 0; i < n && base + i < codes.size(); i++) begin
         gc[i] = codes[base + i];
         ge[i] = eols[base + i];
         gf[i] = eofs[base + i];
      end
      check({tag, "_count"}, 64'(codes.size() - base), 64'(n));
      check({tag, "_codes"}, gc, exp_code);
      check({tag, "_eol"}, ge, exp_eol);
      check({tag, "_eof"}, gf, exp_eof);
      check({tag, "_waits"}, 64'(waits), 64'(exp_waits));
      check({tag, "_done_cnt"}, 64'(fd_cnt - fd0), 64'd1);
      check({tag, "_busy_at_done"}, 64'(busy_at_fd), 64'd0);
      check({tag, "_done_lat"}, 64'(fd_cyc - hs_cyc), 64'd2);
   endtask

   task automatic bad_start(input string tag, input int w, input int h);
      @(posedge clk); #1;
      img_w = XW'(w);
      img_h = 16'(h);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check({tag, "_cfg_err"}, 64'(cfg_err), 64'd1);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      @(negedge clk);
      check({tag, "_pulse"}, 64'(cfg_err), 64'd0);
      check({tag, "_busy2"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int ce0;
      int fd0;
      int waits;
      rst_n   = 1'b0;
      start   = 1'b0;
      img_w   = '0;
      img_h   = '0;
      s_valid = 1'b0;
      s_pix   = '0;
      m_ready = 1'b1;
      #12;
      check("reset_outputs",
            64'({busy, frame_done, cfg_err, s_ready, m_valid, m_code, m_eol, m_eof}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 4x1 all 128: c = 128, 72, 159, 86 -> codes 1,0,1,0
      fill(4, 128);
      run_frame("f4x1", 4, 1, 64'b0101, 64'b1000, 64'b1000, 0, 1'b0);

      // 1x2 of 100: S[0]=500, second c = 131 -> codes 0,1
      fill(2, 100);
      run_frame("f1x2", 1, 2, 64'b10, 64'b11, 64'b10, 1, 1'b0);

      // 8x8 flat black and flat white: zero error everywhere
      fill(64, 0);
      run_frame("f8x8_zero", 8, 8, 64'h0, 64'h8080808080808080, 64'h8000000000000000, 7,
                1'b0);
      fill(64, 255);
      run_frame("f8x8_full", 8, 8, 64'hFFFFFFFFFFFFFFFF, 64'h8080808080808080,
                64'h8000000000000000, 7, 1'b0);

      // Output stall after the 2nd code: codes unchanged, x=3 waits out the stall
      fill(4, 128);
      run_frame("f4x1_stall", 4, 1, 64'b0101, 64'b1000, 64'b1000, 3, 1'b1);

      // Rejected configurations
      ce0 = ce_cnt;
      fd0 = fd_cnt;
      bad_start("cfg_w0", 0, 1);
      bad_start("cfg_wmax", 641, 1);
      bad_start("cfg_h0", 4, 0);
      check("cfg_err_cnt", 64'(ce_cnt - ce0), 64'd3);
      check("cfg_no_done", 64'(fd_cnt - fd0), 64'd0);

      // Reset mid-row aborts everything asynchronously
      fill(4, 128);
      start_frame(4, 1);
      feed(2, waits);
      check("pre_rst_busy", 64'(busy), 64'd1);
      check("pre_rst_valid", 64'(m_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async",
            64'({busy, frame_done, cfg_err, s_ready, m_valid, m_code, m_eol, m_eof}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_frame("f4x1_after_rst", 4, 1, 64'b0101, 64'b1000, 64'b1000, 0, 1'b0);

`ifdef FS_SERPENTINE_EN
      // 2x2: row 0 black, row 1 supplied reversed (x=1 then x=0) -> codes 0,0,1,0
      pix.delete();
      pix.push_back(8'd0);
      pix.push_back(8'd0);
      pix.push_back(8'd128);
      pix.push_back(8'd128);
      run_frame("serp2x2", 2, 2, 64'b0100, 64'b1010, 64'b1000, 1, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
